// File: rtl/vga_rect_fill_master.sv
// Avalon-MM master that fills a clipped rectangle of 2x2-pixel cells in VGA VRAM with one palette index.
// Optional: define RECT_FILL_FRAME_SWAP_EN to add SWAP_FRAME and a frame-toggle write after the fill.
module vga_rect_fill_master #(
  parameter logic [17:0] BASE_ADDR = 18'h00000,
  parameter int          ROW_WORDS = 80,
  parameter int          NUM_ROWS  = 240
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [8:0]  CMD_X,
  input  logic [7:0]  CMD_Y,
  input  logic [8:0]  CMD_W,
  input  logic [7:0]  CMD_H,
  input  logic [7:0]  CMD_COLOR,
`ifdef RECT_FILL_FRAME_SWAP_EN
  input  logic        SWAP_FRAME,
`endif
  output logic [17:0] M_ADDR,
  output logic        M_WRITE,
  output logic [31:0] M_WRITEDATA,
  output logic [3:0]  M_BYTE_EN,
  input  logic        M_WAITREQUEST,
  output logic        BUSY,
  output logic        DONE
);

  localparam logic [9:0] NUM_COLS  = 10'(ROW_WORDS * 4);
  localparam logic [9:0] ROW_LIMIT = 10'(NUM_ROWS);
`ifdef RECT_FILL_FRAME_SWAP_EN
  localparam logic [17:0] SWAP_ADDR = 18'h20000;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_ROW_START,
    S_WRITE,
`ifdef RECT_FILL_FRAME_SWAP_EN
    S_SWAP,
`endif
    S_FINISH
  } state_t;

  state_t      state_reg;
  logic [8:0]  x_reg;
  logic [7:0]  y_reg;
  logic [8:0]  w_reg;
  logic [7:0]  h_reg;
  logic [7:0]  color_reg;
  logic [9:0]  y_end_reg;
  logic [7:0]  row_reg;
  logic [6:0]  word_reg;
  logic [6:0]  first_word_reg;
  logic [6:0]  last_word_reg;
  logic [3:0]  first_mask_reg;
  logic [3:0]  last_mask_reg;
`ifdef RECT_FILL_FRAME_SWAP_EN
  logic        swap_reg;
  logic        frame_reg;
`endif

  logic [9:0]  x_end_sum;
  logic [9:0]  y_end_sum;
  logic [9:0]  x_end_clip;
  logic [9:0]  y_end_clip;
  logic [9:0]  x_last_col;
  logic [9:0]  row_next;
  logic        rect_empty;
  logic [17:0] row_addr;

  // 10-bit sums so x+w / y+h cannot wrap before clipping against the screen edge.
  assign x_end_sum  = {1'b0, x_reg} + {1'b0, w_reg};
  assign y_end_sum  = {2'b00, y_reg} + {2'b00, h_reg};
  assign x_end_clip = (x_end_sum > NUM_COLS) ? NUM_COLS : x_end_sum;
  assign y_end_clip = (y_end_sum > ROW_LIMIT) ? ROW_LIMIT : y_end_sum;
  assign x_last_col = x_end_clip - 10'd1;
  assign row_next   = {2'b00, row_reg} + 10'd1;
  assign rect_empty = (w_reg == 9'd0) || (h_reg == 8'd0) ||
                      ({1'b0, x_reg} >= NUM_COLS) || ({2'b00, y_reg} >= ROW_LIMIT);
  assign row_addr   = BASE_ADDR + 18'(row_reg) * 18'(ROW_WORDS) + {11'd0, first_word_reg};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg      <= S_IDLE;
      CMD_READY      <= 1'b1;
      M_WRITE        <= 1'b0;
      M_ADDR         <= 18'd0;
      M_WRITEDATA    <= 32'd0;
      M_BYTE_EN      <= 4'd0;
      BUSY           <= 1'b0;
      DONE           <= 1'b0;
      x_reg          <= 9'd0;
      y_reg          <= 8'd0;
      w_reg          <= 9'd0;
      h_reg          <= 8'd0;
      color_reg      <= 8'd0;
      y_end_reg      <= 10'd0;
      row_reg        <= 8'd0;
      word_reg       <= 7'd0;
      first_word_reg <= 7'd0;
      last_word_reg  <= 7'd0;
      first_mask_reg <= 4'd0;
      last_mask_reg  <= 4'd0;
`ifdef RECT_FILL_FRAME_SWAP_EN
      swap_reg       <= 1'b0;
      frame_reg      <= 1'b0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (CMD_VALID) begin
            x_reg     <= CMD_X;
            y_reg     <= CMD_Y;
            w_reg     <= CMD_W;
            h_reg     <= CMD_H;
            color_reg <= CMD_COLOR;
`ifdef RECT_FILL_FRAME_SWAP_EN
            swap_reg  <= SWAP_FRAME;
`endif
            CMD_READY <= 1'b0;
            BUSY      <= 1'b1;
            state_reg <= S_ACCEPT;
          end
        end

        S_ACCEPT: begin
          y_end_reg      <= y_end_clip;
          row_reg        <= y_reg;
          first_word_reg <= x_reg[8:2];
          last_word_reg  <= x_last_col[8:2];
          first_mask_reg <= 4'b1111 << x_reg[1:0];
          last_mask_reg  <= 4'b1111 >> (2'd3 - x_last_col[1:0]);
          if (!rect_empty) begin
            state_reg <= S_ROW_START;
`ifdef RECT_FILL_FRAME_SWAP_EN
          end else if (swap_reg) begin
            M_WRITE     <= 1'b1;
            M_ADDR      <= SWAP_ADDR;
            M_WRITEDATA <= {31'd0, ~frame_reg};
            M_BYTE_EN   <= 4'b1111;
            state_reg   <= S_SWAP;
`endif
          end else begin
            DONE      <= 1'b1;
            state_reg <= S_FINISH;
          end
        end

        S_ROW_START: begin
          word_reg    <= first_word_reg;
          M_ADDR      <= row_addr;
          M_WRITEDATA <= {4{color_reg}};
          M_BYTE_EN   <= (first_word_reg == last_word_reg) ? (first_mask_reg & last_mask_reg)
                                                           : first_mask_reg;
          M_WRITE     <= 1'b1;
          state_reg   <= S_WRITE;
        end

        S_WRITE: begin
          // Outputs only move on a completed transfer, so they hold through any stall.
          if (!M_WAITREQUEST) begin
            if (word_reg != last_word_reg) begin
              word_reg  <= word_reg + 7'd1;
              M_ADDR    <= M_ADDR + 18'd1;
              M_BYTE_EN <= ((word_reg + 7'd1) == last_word_reg) ? last_mask_reg : 4'b1111;
            end else if (row_next < y_end_reg) begin
              row_reg   <= row_reg + 8'd1;
              M_WRITE   <= 1'b0;
              state_reg <= S_ROW_START;
`ifdef RECT_FILL_FRAME_SWAP_EN
            end else if (swap_reg) begin
              M_ADDR      <= SWAP_ADDR;
              M_WRITEDATA <= {31'd0, ~frame_reg};
              M_BYTE_EN   <= 4'b1111;
              state_reg   <= S_SWAP;
`endif
            end else begin
              M_WRITE   <= 1'b0;
              DONE      <= 1'b1;
              state_reg <= S_FINISH;
            end
          end
        end

`ifdef RECT_FILL_FRAME_SWAP_EN
        S_SWAP: begin
          if (!M_WAITREQUEST) begin
            M_WRITE   <= 1'b0;
            frame_reg <= ~frame_reg;
            DONE      <= 1'b1;
            state_reg <= S_FINISH;
          end
        end
`endif

        S_FINISH: begin
          DONE      <= 1'b0;
          BUSY      <= 1'b0;
          CMD_READY <= 1'b1;
          state_reg <= S_IDLE;
        end

        default: begin
          M_WRITE   <= 1'b0;
          DONE      <= 1'b0;
          BUSY      <= 1'b0;
          CMD_READY <= 1'b1;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_rect_fill_master.sv
// Directed bench for vga_rect_fill_master: a negedge slave model logs writes and checks stall stability,
// one initial block drives commands and compares against hand-computed addresses, masks and data.
module tb_vga_rect_fill_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic [8:0]  cmd_w;
  logic [7:0]  cmd_h;
  logic [7:0]  cmd_color;
  logic        swap_frame;
  logic [17:0] m_addr;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [3:0]  m_byte_en;
  logic        m_waitrequest = 1'b0;
  logic        busy;
  logic        done;

  vga_rect_fill_master dut (
    .CLK           (clk),
    .RESET         (rst),
    .CMD_VALID     (cmd_valid),
    .CMD_READY     (cmd_ready),
    .CMD_X         (cmd_x),
    .CMD_Y         (cmd_y),
    .CMD_W         (cmd_w),
    .CMD_H         (cmd_h),
    .CMD_COLOR     (cmd_color),
`ifdef RECT_FILL_FRAME_SWAP_EN
    .SWAP_FRAME    (swap_frame),
`endif
    .M_ADDR        (m_addr),
    .M_WRITE       (m_write),
    .M_WRITEDATA   (m_writedata),
    .M_BYTE_EN     (m_byte_en),
    .M_WAITREQUEST (m_waitrequest),
    .BUSY          (busy),
    .DONE          (done)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model / monitor state (written only by the negedge process)
  int          stall_mode = 0;     // 0: never stall, 1: 3 stall cycles per write
  int          stall_cnt = 0;
  int          stall_cycles = 0;
  int          stall_err = 0;
  int          proto_err = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic        held_valid = 1'b0;
  logic [54:0] held;
  logic [17:0] wa_q[$];
  logic [3:0]  wb_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];

  always @(negedge clk) begin
    if (held_valid && !rst && ({m_addr, m_writedata, m_byte_en, m_write} !== held))
      stall_err++;
    held_valid = 1'b0;
    if (m_write && !rst) begin
      if (stall_mode == 1 && stall_cnt < 3) begin
        m_waitrequest = 1'b1;
        stall_cnt++;
      end else begin
        m_waitrequest = 1'b0;
        stall_cnt = 0;
      end
      if (m_byte_en == 4'd0 || m_addr[17:16] != 2'b00) proto_err++;
      if (m_waitrequest) begin
        held = {m_addr, m_writedata, m_byte_en, m_write};
        held_valid = 1'b1;
        stall_cycles++;
      end else begin
        wa_q.push_back(m_addr);
        wb_q.push_back(m_byte_en);
        wd_q.push_back(m_writedata);
        wc_q.push_back(cyc);
        $display("wr addr=%0d be=%b data=%h cyc=%0d", m_addr, m_byte_en, m_writedata, cyc);
      end
    end else begin
      m_waitrequest = 1'b0;
      stall_cnt = 0;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [8:0] x, input logic [7:0] y, input logic [8:0] w,
                          input logic [7:0] h, input logic [7:0] c, output int acc_cyc);
    int n = 0;
    cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = c;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    cmd_valid = 1'b0;
    $display("cmd x=%0d y=%0d w=%0d h=%0d color=%h accepted cyc=%0d", x, y, w, h, c, acc_cyc);
  endtask

  task automatic wait_done(input int budget);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", done_cnt - start, 1);
    chk("done_one_cycle", done, 0);
    chk("busy_cleared", busy, 0);
    chk("ready_restored", cmd_ready, 1);
  endtask

  task automatic chk_write(input string tag, input int idx, input logic [17:0] a,
                           input logic [3:0] b, input logic [31:0] d);
    if (idx < wa_q.size()) begin
      chk({tag, "_addr"}, wa_q[idx], a);
      chk({tag, "_be"}, wb_q[idx], b);
      chk({tag, "_data"}, wd_q[idx], d);
    end else begin
      chk({tag, "_missing"}, wa_q.size(), idx + 1);
    end
  endtask

  initial begin
    int base;
    int acc;
    int d0;
    int n;
    rst = 1'b1; cmd_valid = 1'b0; swap_frame = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_write", m_write, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_data", m_writedata, 0);
    chk("rst_be", m_byte_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;

    // Full first row: 80 back-to-back words
    base = wa_q.size();
    send_cmd(9'd0, 8'd0, 9'd320, 8'd1, 8'h05, acc);
    chk("t1_busy", busy, 1);
    chk("t1_not_ready", cmd_ready, 0);
    wait_done(400);
    chk("t1_count", wa_q.size() - base, 80);
    for (int i = 0; i < 80; i++)
      chk_write("t1", base + i, 18'(i), 4'b1111, 32'h05050505);
    if (wa_q.size() >= base + 80) begin
      chk("t1_back_to_back", wc_q[base + 79] - wc_q[base], 79);
      chk("t1_done_latency", done_cyc - wc_q[base + 79], 1);
    end

    // Single word with both edge masks
    base = wa_q.size();
    send_cmd(9'd5, 8'd2, 9'd2, 8'd1, 8'hA1, acc);
    wait_done(50);
    chk("t2_count", wa_q.size() - base, 1);
    chk_write("t2", base, 18'd161, 4'b0110, 32'hA1A1A1A1);

    // Bottom-right corner, clipped to 2x1
    base = wa_q.size();
    send_cmd(9'd318, 8'd239, 9'd10, 8'd10, 8'h3C, acc);
    wait_done(50);
    chk("t3_count", wa_q.size() - base, 1);
    chk_write("t3", base, 18'd19199, 4'b1100, 32'h3C3C3C3C);

    // Two rows of three words, each write stalled three cycles
    stall_mode = 1;
    base = wa_q.size();
    d0 = stall_cycles;
    n = stall_err;
    send_cmd(9'd3, 8'd10, 9'd6, 8'd2, 8'h7E, acc);
    wait_done(200);
    stall_mode = 0;
    chk("t4_count", wa_q.size() - base, 6);
    chk_write("t4_w0", base + 0, 18'd800, 4'b1000, 32'h7E7E7E7E);
    chk_write("t4_w1", base + 1, 18'd801, 4'b1111, 32'h7E7E7E7E);
    chk_write("t4_w2", base + 2, 18'd802, 4'b0001, 32'h7E7E7E7E);
    chk_write("t4_w3", base + 3, 18'd880, 4'b1000, 32'h7E7E7E7E);
    chk_write("t4_w4", base + 4, 18'd881, 4'b1111, 32'h7E7E7E7E);
    chk_write("t4_w5", base + 5, 18'd882, 4'b0001, 32'h7E7E7E7E);
    chk("t4_stall_cycles", stall_cycles - d0, 18);
    chk("t4_stall_stable", stall_err - n, 0);

    // Empty rectangles: zero width, then off-screen X
    base = wa_q.size();
    send_cmd(9'd10, 8'd10, 9'd0, 8'd5, 8'h44, acc);
    wait_done(20);
    chk("t5_w0_writes", wa_q.size() - base, 0);
    chk("t5_w0_latency_ok", (done_cyc - acc) <= 3, 1);
    send_cmd(9'd400, 8'd10, 9'd4, 8'd5, 8'h44, acc);
    wait_done(20);
    chk("t5_x400_writes", wa_q.size() - base, 0);
    chk("t5_x400_latency_ok", (done_cyc - acc) <= 3, 1);

    // Reset in the middle of a stalled row
    stall_mode = 1;
    base = wa_q.size();
    d0 = done_cnt;
    send_cmd(9'd0, 8'd0, 9'd320, 8'd1, 8'h22, acc);
    n = 0;
    while (wa_q.size() < base + 3 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_progress", wa_q.size() >= base + 3, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_write_dropped", m_write, 0);
    chk("t6_ready", cmd_ready, 1);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    stall_mode = 0;
    base = wa_q.size();
    repeat (10) @(posedge clk);
    #1;
    chk("t6_no_writes", wa_q.size() - base, 0);
    chk("t6_no_done", done_cnt - d0, 0);

    // Fill still works after reset (with frame swap when built with the option)
    swap_frame = 1'b1;
    base = wa_q.size();
    send_cmd(9'd0, 8'd5, 9'd4, 8'd1, 8'h11, acc);
    wait_done(50);
    chk_write("t7", base, 18'd400, 4'b1111, 32'h11111111);
`ifdef RECT_FILL_FRAME_SWAP_EN
    chk("t7_count", wa_q.size() - base, 2);
    chk_write("t7_swap", base + 1, 18'h20000, 4'b1111, 32'h00000001);
`else
    chk("t7_count", wa_q.size() - base, 1);
`endif
    chk("proto_errors", proto_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
